// File: rtl/wb_arbiter_if.sv
// Bundle of requester-side and shared-bus signals for the round-robin wishbone arbiter.
// The master modport is the arbiter's view; slave is the view of requesters plus shared slave.
interface wb_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_wdata;
  logic [N-1:0]    s_we;
  logic [N-1:0]    s_cyc;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_ack;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_we;
  logic            m_cyc;
  logic [DW-1:0]   m_rdata;
  logic            m_ack;
  logic            tm_err;

  modport master (
    input  s_addr, s_wdata, s_we, s_cyc, m_rdata, m_ack,
    output s_rdata, s_ack, m_addr, m_wdata, m_we, m_cyc, tm_err
  );

  modport slave (
    output s_addr, s_wdata, s_we, s_cyc, m_rdata, m_ack,
    input  s_rdata, s_ack, m_addr, m_wdata, m_we, m_cyc, tm_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// N-to-1 round-robin wishbone arbiter, one whole cyc..ack transaction per grant.
// Optional bus-hang timeout abort enabled by defining WB_ARB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | m_cyc low, pick next requester after last served
//   BUSY  | m_cyc high for granted requester until ack, abort or timeout
module wb_arbiter #(
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  wb_arbiter_if.master bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state;
  logic [N-1:0]  r_grant;
  logic [IW-1:0] r_gidx;
  logic [IW-1:0] r_last;
  logic          r_m_cyc;

  logic [IW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic          w_tmo;
  logic          w_ack;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_tcnt;
  assign w_tmo = r_m_cyc && (r_tcnt == CW'(TIMEOUT)) && !bus.m_ack;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT != 0);
  assign w_tmo        = 1'b0;
`endif

  // Scan starts just after the last served requester, so it has lowest priority.
  always_comb begin
    w_pick_any = 1'b0;
    w_pick_idx = r_last;
    for (int k = 1; k <= N; k++) begin
      if (!w_pick_any && bus.s_cyc[IW'((int'(r_last) + k) % N)]) begin
        w_pick_any = 1'b1;
        w_pick_idx = IW'((int'(r_last) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(N - 1);
      r_m_cyc <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      r_tcnt  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state <= BUSY;
            r_grant <= N'(1) << w_pick_idx;
            r_gidx  <= w_pick_idx;
            r_m_cyc <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus.m_ack || w_tmo) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= r_gidx;
            r_m_cyc <= 1'b0;
          end else if (!bus.s_cyc[r_gidx]) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_m_cyc <= 1'b0;
          end else begin
`ifdef WB_ARB_TIMEOUT_EN
            r_tcnt  <= r_tcnt + CW'(1);
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_m_cyc <= 1'b0;
        end
      endcase
    end
  end

  assign w_ack      = r_m_cyc && (bus.m_ack || w_tmo);
  assign bus.m_cyc  = r_m_cyc;
  assign bus.s_ack  = w_ack ? r_grant : '0;
  assign bus.tm_err = w_tmo;

  // Address/data keep following the last grant in IDLE; only m_we is qualified.
  always_comb begin
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_we    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_gidx == IW'(i)) begin
        bus.m_addr  = bus.s_addr[i*AW +: AW];
        bus.m_wdata = bus.s_wdata[i*DW +: DW];
        bus.m_we    = r_m_cyc & bus.s_we[i];
      end
    end
  end

  always_comb begin
    bus.s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_ack && r_grant[i]) begin
        bus.s_rdata[i*DW +: DW] = w_tmo ? {DW{1'b1}} : bus.m_rdata;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a transaction-level reference model.
module tb_wb_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.N(N), .DW(DW), .AW(AW)) bus ();

  wb_arbiter #(.N(N), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the bus (-1 = nobody), who was served last, busy cycles so far.
  int owner = -1;
  int last  = N - 1;
  int tcnt  = 0;
  logic hit;
  logic [N-1:0] exp_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [N*DW-1:0] exp_rd;
    @(negedge clk);
    hit = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    hit = (owner >= 0) && (tcnt == TO) && !bus.m_ack;
`endif
    exp_ack = '0;
    exp_rd  = '0;
    if (owner >= 0 && (bus.m_ack || hit)) begin
      exp_ack[owner] = 1'b1;
      exp_rd[owner*DW +: DW] = hit ? {DW{1'b1}} : bus.m_rdata;
    end
    chk("m_cyc",   64'(bus.m_cyc),   64'(owner >= 0));
    chk("m_we",    64'(bus.m_we),    64'((owner >= 0) ? bus.s_we[owner] : 1'b0));
    chk("s_ack",   64'(bus.s_ack),   64'(exp_ack));
    chk("s_rdata", 64'(bus.s_rdata), 64'(exp_rd));
    chk("tm_err",  64'(bus.tm_err),  64'(hit));
    if (owner >= 0) begin
      chk("m_addr",  64'(bus.m_addr),  64'(bus.s_addr[owner*AW +: AW]));
      chk("m_wdata", 64'(bus.m_wdata), 64'(bus.s_wdata[owner*DW +: DW]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      owner = -1;
      last  = N - 1;
      tcnt  = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (owner < 0 && bus.s_cyc[(last + k) % N]) owner = (last + k) % N;
      tcnt = 0;
    end else if (bus.m_ack || hit) begin
      last  = owner;
      owner = -1;
    end else if (!bus.s_cyc[owner]) begin
      owner = -1;
    end else begin
      tcnt++;
    end
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic we, input logic cyc);
    bus.s_addr[i*AW +: AW]  = a;
    bus.s_wdata[i*DW +: DW] = d;
    bus.s_we[i]             = we;
    bus.s_cyc[i]            = cyc;
  endtask

  // Ends in a sampled (not yet advanced) cycle where m_cyc is high, or a failed check.
  task automatic wait_cyc(output int idle);
    idle = 0;
    sample();
    while (!bus.m_cyc && idle < 20) begin
      advance();
      sample();
      idle++;
    end
    chk("wait_m_cyc", 64'(bus.m_cyc), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idle;
    rst         = 1'b1;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_we    = '0;
    bus.s_cyc   = '0;
    bus.m_rdata = '0;
    bus.m_ack   = 1'b0;
    exp_ack     = '0;
    advance();
    advance();
    rst = 1'b0;
    tick();

    // Single read by requester 0, acked on the fourth m_cyc cycle.
    set_req(0, 16'h0100, 16'h0000, 1'b0, 1'b1);
    sample();
    chk("t1_cyc_pre", 64'(bus.m_cyc), 64'd0);
    advance();
    sample();
    chk("t1_cyc_rise", 64'(bus.m_cyc), 64'd1);
    advance();
    tick();
    tick();
    bus.m_ack = 1'b1;
    bus.m_rdata = 16'hA5A5;
    sample();
    chk("t1_ack", 64'(bus.s_ack), 64'h1);
    chk("t1_rdata", 64'(bus.s_rdata[0 +: DW]), 64'hA5A5);
    advance();
    bus.m_ack = 1'b0;
    set_req(0, 16'h0100, 16'h0000, 1'b0, 1'b0);
    sample();
    chk("t1_rdata_after", 64'(bus.s_rdata), 64'h0);
    advance();

    // All four request continuously after reset: order 0,1,2,3,0 with one idle cycle each.
    for (int i = 0; i < N; i++) set_req(i, AW'(16'h1000 + i), DW'(16'h3000 + i), 1'b0, 1'b1);
    rst = 1'b1;
    advance();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_cyc(idle);
      chk("t2_gap", 64'(idle), 64'd1);
      chk("t2_grant", 64'(bus.m_addr), 64'(16'h1000 + (k % N)));
      advance();
      bus.m_ack   = 1'b1;
      bus.m_rdata = DW'(16'h2000 + k);
      sample();
      chk("t2_ack", 64'(bus.s_ack), 64'(1 << (k % N)));
      advance();
      bus.m_ack = 1'b0;
    end
    bus.s_cyc = '0;
    tick();

    // Requester 2 writes while requester 1 is idle.
    set_req(2, 16'h0010, 16'h1234, 1'b1, 1'b1);
    wait_cyc(idle);
    chk("t3_addr", 64'(bus.m_addr), 64'h0010);
    chk("t3_wdata", 64'(bus.m_wdata), 64'h1234);
    chk("t3_we", 64'(bus.m_we), 64'd1);
    advance();
    bus.m_ack = 1'b1;
    sample();
    chk("t3_ack", 64'(bus.s_ack), 64'h4);
    advance();
    bus.m_ack = 1'b0;
    set_req(2, 16'h0010, 16'h1234, 1'b1, 1'b0);
    sample();
    chk("t3_we_after", 64'(bus.m_we), 64'd0);
    advance();

    // Requester 1 aborts mid-transaction; a stray ack follows two cycles later.
    set_req(1, 16'h0200, 16'h0000, 1'b0, 1'b1);
    wait_cyc(idle);
    advance();
    bus.s_cyc[1] = 1'b0;
    sample();
    advance();
    sample();
    chk("t4_cyc_fall", 64'(bus.m_cyc), 64'd0);
    advance();
    bus.m_ack = 1'b1;
    bus.m_rdata = 16'hBEEF;
    sample();
    chk("t4_stray_ack", 64'(bus.s_ack), 64'h0);
    chk("t4_stray_rdata", 64'(bus.s_rdata), 64'h0);
    advance();
    bus.m_ack = 1'b0;

    // Reset during BUSY for requester 3; afterwards requester 0 wins over 3.
    set_req(3, 16'h0300, 16'h0000, 1'b0, 1'b1);
    wait_cyc(idle);
    chk("t5_owner3", 64'(bus.m_addr), 64'h0300);
    advance();
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    set_req(0, 16'h0400, 16'h0000, 1'b0, 1'b1);
    sample();
    chk("t5_cyc_rst", 64'(bus.m_cyc), 64'd0);
    chk("t5_ack_rst", 64'(bus.s_ack), 64'h0);
    advance();
    wait_cyc(idle);
    chk("t5_grant0", 64'(bus.m_addr), 64'h0400);
    advance();
    bus.m_ack = 1'b1;
    sample();
    chk("t5_ack0", 64'(bus.s_ack), 64'h1);
    advance();
    bus.m_ack = 1'b0;
    bus.s_cyc = '0;
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: forced abort on the ninth m_cyc cycle.
    set_req(1, 16'h0500, 16'h0000, 1'b0, 1'b1);
    wait_cyc(idle);
    repeat (8) begin
      advance();
      sample();
    end
    chk("t6_tm_err", 64'(bus.tm_err), 64'd1);
    chk("t6_tm_ack", 64'(bus.s_ack), 64'h2);
    chk("t6_tm_rdata", 64'(bus.s_rdata[DW +: DW]), 64'hFFFF);
    advance();
    bus.s_cyc[1] = 1'b0;
    sample();
    chk("t6_tm_drop", 64'(bus.m_cyc), 64'd0);
    advance();
    // Ack arriving on the ninth cycle wins over the timeout.
    set_req(1, 16'h0500, 16'h0000, 1'b0, 1'b1);
    wait_cyc(idle);
    repeat (7) begin
      advance();
      sample();
    end
    advance();
    bus.m_ack = 1'b1;
    bus.m_rdata = 16'h5A5A;
    sample();
    chk("t6_ack_tm_err", 64'(bus.tm_err), 64'd0);
    chk("t6_ack_rdata", 64'(bus.s_rdata[DW +: DW]), 64'h5A5A);
    advance();
    bus.m_ack = 1'b0;
    bus.s_cyc = '0;
    tick();
`endif

    // Random requesters, random acks (including stray ones) and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      bus.m_ack   = ($urandom_range(0, 2) == 0);
      bus.m_rdata = DW'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!bus.s_cyc[i]) begin
          if ($urandom_range(0, 3) == 0)
            set_req(i, AW'($urandom), DW'($urandom), 1'($urandom), 1'b1);
        end else if (exp_ack[i]) begin
          if ($urandom_range(0, 1) == 0) bus.s_cyc[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          bus.s_cyc[i] = 1'b0;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
